// File: rtl/ram_0_sdp_pkg.sv
// Shared defaults and option strings for the simple dual-port RAM slice.
`timescale 1ns/1ps
package ram_0_sdp_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 8;

  localparam string FMT_BIN   = "BIN";
  localparam string FMT_HEX   = "HEX";
  localparam string RST_ASYNC = "ASYNC";
  localparam string RST_SYNC  = "SYNC";

endpackage

// File: rtl/ram_0_sdp_array.sv
// Storage array with its wr_clk write port and the stage-1 read register
// (registered address plus a live flag that holds the read word at zero in reset).
`timescale 1ns/1ps
module ram_0_sdp_array
  import ram_0_sdp_pkg::*;
#(
  parameter int    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter bit    SYNC_RST    = 1'b0,
  parameter bit    INIT_ENABLE = 1'b0,
  parameter string INIT_FILE   = "NONE",
  parameter string FILE_FORMAT = FMT_BIN
) (
  input  logic                  wr_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_word
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic                  live_d, live_q;

  // Power-up image: all zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // NOTE: the array has no reset term; clearing a RAM is not a one-cycle
  // operation and would stop it mapping onto memory primitives.
  always_ff @(posedge wr_clk) begin
    // NOTE: clocked state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of block ordering.
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // can leave it unassigned and infer a latch.
    addr_d = rd_addr;
    live_d = 1'b1;
  end

  if (SYNC_RST) begin : g_sync_rst
    always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
        addr_q <= '0;
        live_q <= 1'b0;
      end else begin
        addr_q <= addr_d;
        live_q <= live_d;
      end
    end
  end else begin : g_async_rst
    always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
        addr_q <= '0;
        live_q <= 1'b0;
      end else begin
        addr_q <= addr_d;
        live_q <= live_d;
      end
    end
  end

  // A write landing mid-period may show through as the new word; both are legal.
  always_comb begin
    rd_word = '0;
    if (live_q) rd_word = mem[addr_q];
  end

endmodule

// File: rtl/ram_0_sdp.sv
// Simple dual-port RAM top: array plus optional read output register, with
// the read path reset either asynchronously or on the next rd_clk_tb edge.
`timescale 1ns/1ps
module ram_0_sdp
  import ram_0_sdp_pkg::*;
#(
  parameter int    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int    OUT_REG     = 1,
  parameter string RST_TYPE    = RST_ASYNC,
  parameter int    INIT_ENABLE = 0,
  parameter string INIT_FILE   = "NONE",
  parameter string FILE_FORMAT = FMT_BIN
) (
  input  logic                  rd_clk_tb,
  input  logic                  tb_rst,
  input  logic                  wr_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam bit SYNC_RST = (RST_TYPE == RST_SYNC);

  logic [DATA_WIDTH-1:0] stage1_word;

  ram_0_sdp_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_RST   (SYNC_RST),
    .INIT_ENABLE(INIT_ENABLE != 0),
    .INIT_FILE  (INIT_FILE),
    .FILE_FORMAT(FILE_FORMAT)
  ) u_array (
    .wr_clk (wr_clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_clk (rd_clk_tb),
    .rd_rst (tb_rst),
    .rd_addr(rd_addr),
    .rd_word(stage1_word)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout_d, dout_q;

    always_comb begin
      dout_d = stage1_word;
    end

    if (SYNC_RST) begin : g_sync_rst
      always_ff @(posedge rd_clk_tb) begin
        if (tb_rst) dout_q <= '0;
        else        dout_q <= dout_d;
      end
    end else begin : g_async_rst
      always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
        if (tb_rst) dout_q <= '0;
        else        dout_q <= dout_d;
      end
    end

    assign rd_data = dout_q;
  end else begin : g_no_out_reg
    assign rd_data = stage1_word;
  end

endmodule

// File: tb/tb_ram_0_sdp.sv
// Directed bench for ram_0_sdp with default parameters (OUT_REG=1, ASYNC reset).
`timescale 1ns/1ps
module tb_ram_0_sdp;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  localparam logic [DW-1:0] BB_VALS [8] = '{8'h12, 8'h34, 8'h56, 8'h78,
                                            8'h9A, 8'hBC, 8'hDE, 8'hF1};

  logic          rd_clk_tb;
  logic          wr_clk;
  logic          tb_rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  int errors;
  int checks;

  ram_0_sdp dut (
    .rd_clk_tb(rd_clk_tb),
    .tb_rst   (tb_rst),
    .wr_clk   (wr_clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  // Read clock runs at twice the write clock rate.
  initial begin
    rd_clk_tb = 1'b0;
    forever #5 rd_clk_tb = ~rd_clk_tb;
  end

  initial begin
    wr_clk = 1'b0;
    forever #10 wr_clk = ~wr_clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time budget exceeded at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[0] ? 8'hFF : 8'h00;
  endfunction

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge wr_clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge wr_clk);
    wr_en   = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge rd_clk_tb);
    rd_addr = a;
    repeat (2) @(posedge rd_clk_tb);
    #1 d = rd_data;
  endtask

  task automatic test_reset();
    logic [DW-1:0] got;
    tb_rst = 1'b1;
    #1;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_immediate: got %h expected 00", rd_data);
    end
    checks++;
    fork
      begin
        write_word(10'd7, 8'h5A);
        write_word(10'd8, 8'hC3);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge rd_clk_tb);
          if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %h expected 00", i, rd_data);
          end
          checks++;
          rd_addr = (i % 2 == 0) ? 10'd7 : 10'd8;
        end
      end
    join
    @(negedge rd_clk_tb);
    tb_rst = 1'b0;
    read_word(10'd7, got);
    if (got !== 8'h5A) begin
      errors++;
      $display("FAIL write_during_reset a7: got %h expected 5a", got);
    end
    checks++;
    read_word(10'd8, got);
    if (got !== 8'hC3) begin
      errors++;
      $display("FAIL write_during_reset a8: got %h expected c3", got);
    end
    checks++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      write_word(AW'(i + 1), pat(AW'(i + 1)));
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] got;
    read_word(10'd2, got);
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL latency_pre a2: got %h expected 00", got);
    end
    checks++;
    @(negedge rd_clk_tb);
    rd_addr = 10'd3;
    @(posedge rd_clk_tb);
    #1;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL latency_edge1: got %h expected 00", rd_data);
    end
    checks++;
    @(posedge rd_clk_tb);
    #1;
    if (rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL latency_edge2: got %h expected ff", rd_data);
    end
    checks++;
  endtask

  task automatic test_sweep();
    logic [DW-1:0] got;
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      read_word(AW'(i), got);
      if (got !== pat(AW'(i))) begin
        errors++;
        $display("FAIL sweep a%0d: got %h expected %h", i, got, pat(AW'(i)));
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] got;
    logic [AW-1:0] addrs [5];
    addrs = '{10'd1, 10'd2, 10'd1023, 10'd0, 10'd512};
    read_word(10'd3, got);
    if (got !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_pre: got %h expected ff", got);
    end
    checks++;
    @(posedge rd_clk_tb);
    #3 tb_rst = 1'b1;
    #1;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_immediate: got %h expected 00", rd_data);
    end
    checks++;
    rd_addr = 10'd1;
    repeat (2) begin
      @(negedge rd_clk_tb);
      if (rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_hold: got %h expected 00", rd_data);
      end
      checks++;
    end
    @(negedge rd_clk_tb);
    rd_addr = 10'd3;
    tb_rst  = 1'b0;
    @(posedge rd_clk_tb);
    #1;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_edge1: got %h expected 00", rd_data);
    end
    checks++;
    @(posedge rd_clk_tb);
    #1;
    if (rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL post_reset_edge2: got %h expected ff", rd_data);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      read_word(addrs[i], got);
      if (got !== pat(addrs[i])) begin
        errors++;
        $display("FAIL post_reset_read a%0d: got %h expected %h", addrs[i], got, pat(addrs[i]));
      end
      checks++;
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] got;
    write_word(10'd5, 8'hA5);
    read_word(10'd5, got);
    if (got !== 8'hA5) begin
      errors++;
      $display("FAIL write_read a5: got %h expected a5", got);
    end
    checks++;
    @(negedge wr_clk);
    wr_en   = 1'b0;
    wr_addr = 10'd5;
    wr_data = 8'h3C;
    repeat (2) @(negedge wr_clk);
    read_word(10'd5, got);
    if (got !== 8'hA5) begin
      errors++;
      $display("FAIL wr_en_low a5: got %h expected a5", got);
    end
    checks++;
    read_word(10'd4, got);
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL neighbour a4: got %h expected 00", got);
    end
    checks++;
    read_word(10'd6, got);
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL neighbour a6: got %h expected 00", got);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) write_word(AW'(200 + k), BB_VALS[k]);
    for (int k = 0; k < 9; k++) begin
      @(negedge rd_clk_tb);
      rd_addr = AW'(200 + ((k < 8) ? k : 7));
      @(posedge rd_clk_tb);
      #1;
      if (k >= 1) begin
        if (rd_data !== BB_VALS[k-1]) begin
          errors++;
          $display("FAIL back_to_back a%0d: got %h expected %h", 200 + k - 1, rd_data, BB_VALS[k-1]);
        end
        checks++;
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    tb_rst  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    #1;
    test_reset();
    test_fill();
    test_latency();
    test_sweep();
    test_reset_mid();
    test_write_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
